// File: rtl/twos_compliment_mc_pkg.sv
// Shared definitions for the multi-channel serial two's-complement unit.
//   mode_e   : per-word operation selected on the in_first beat
//   cstate_e : per-lane complement state machine (S1 = copy, S2 = invert)
//   negate_flag() : decides whether a completed word is negated
package twos_compliment_mc_pkg;

    typedef enum logic [1:0] {
        MODE_PASS     = 2'd0,
        MODE_NEG      = 2'd1,
        MODE_ABS      = 2'd2,
        MODE_PASS_ALT = 2'd3
    } mode_e;

    typedef enum logic {
        ST_S1 = 1'b0,
        ST_S2 = 1'b1
    } cstate_e;

    // abs negates only words whose sign bit is set
    function automatic logic negate_flag(input mode_e m, input logic msb);
        logic neg;
        case (m)
            MODE_NEG: neg = 1'b1;
            MODE_ABS: neg = msb;
            default:  neg = 1'b0;
        endcase
        return neg;
    endfunction

endpackage

// File: rtl/twos_compliment_lane.sv
// One serial lane: capture shift register, emit buffer, negate flag,
// S1/S2 complement FSM and most-negative-value overflow tracker.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   cap_en_i      : accepted input beat, shift din_i into the capture register
//   din_i         : serial input bit for this lane
//   load_i        : last beat of a word accepted; move word to emit buffer
//   mode_i        : latched word mode (valid with load_i)
//   emit_en_i     : emission cycle in progress
//   emit_last_i   : current emission cycle carries the MSB
//   out_o         : serial result bit (0 outside emission)
//   ovf_o         : overflow flag, only asserted on the MSB cycle
module twos_compliment_lane
    import twos_compliment_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cap_en_i,
    input  logic       din_i,
    input  logic       load_i,
    input  logic [1:0] mode_i,
    input  logic       emit_en_i,
    input  logic       emit_last_i,
    output logic       out_o,
    output logic       ovf_o
);

    // Only WIDTH-1 bits are held: the final bit arrives on din_i in the
    // same cycle the word is handed to the emit buffer.
    logic [WIDTH-2:0] cap_q, cap_d;
    logic [WIDTH-1:0] emit_q, emit_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;
    cstate_e          st_q, st_d;

    logic [WIDTH-1:0] word;
    logic             cur_bit;

    // New bits enter at the top so bit 0 ends up at the LSB after WIDTH beats
    assign word    = {din_i, cap_q};
    assign cur_bit = emit_q[0];

    always_comb begin
        cap_d  = cap_q;
        emit_d = emit_q;
        neg_d  = neg_q;
        zero_d = zero_q;
        st_d   = st_q;
        if (cap_en_i) begin
            cap_d = word[WIDTH-1:1];
        end
        if (load_i) begin
            // din_i is the MSB of the completing word
            emit_d = word;
            neg_d  = negate_flag(mode_e'(mode_i), din_i);
            zero_d = 1'b1;
            st_d   = ST_S1;
        end else if (emit_en_i) begin
            emit_d = emit_q >> 1;
            zero_d = zero_q & ~cur_bit;
            case (st_q)
                ST_S1:   st_d = cur_bit ? ST_S2 : ST_S1;
                default: st_d = ST_S2;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q  <= '0;
            emit_q <= '0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
            st_q   <= ST_S1;
        end else begin
            cap_q  <= cap_d;
            emit_q <= emit_d;
            neg_q  <= neg_d;
            zero_q <= zero_d;
            st_q   <= st_d;
        end
    end

    always_comb begin
        out_o = 1'b0;
        ovf_o = 1'b0;
        if (emit_en_i) begin
            out_o = (neg_q && st_q == ST_S2) ? ~cur_bit : cur_bit;
            // zero_q covers every bit below the MSB by the last cycle
            ovf_o = emit_last_i & neg_q & cur_bit & zero_q;
        end
    end

endmodule

// File: rtl/twos_compliment_mc.sv
// Multi-channel word-framed bit-serial two's-complement unit.
// Shared framing (beat counter, word-in-progress flag, latched mode,
// emit counter) lives here; per-lane datapaths are twos_compliment_lane.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in[CHANNELS]       : serial data, LSB first
//   in_valid, in_first : beat qualifier / LSB-beat marker
//   mode[2]            : 0 pass, 1 negate, 2 abs, 3 pass (sampled on in_first)
//   out[CHANNELS]      : serial result, LSB first
//   out_valid          : result bit present
//   out_first/out_last : LSB / MSB beat of an output word
//   ovf[CHANNELS]      : most-negative negation, valid with out_last
module twos_compliment_mc
    import twos_compliment_mc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    input  logic                in_valid,
    input  logic                in_first,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] out,
    output logic                out_valid,
    output logic                out_first,
    output logic                out_last,
    output logic [CHANNELS-1:0] ovf
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic          act_q, act_d;
    logic [CW-1:0] ecnt_q, ecnt_d;

    logic accept;
    logic complete;

    // Beats without in_first are only meaningful inside a word
    assign accept   = in_valid & (in_first | busy_q);
    assign complete = in_valid & ~in_first & busy_q & (cnt_q == LAST);

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (in_valid && in_first) begin
            // Also restarts a word already in progress
            busy_d = 1'b1;
            cnt_d  = CW'(1);
            mode_d = mode;
        end else if (in_valid && busy_q) begin
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // A completing word takes priority: it can only coincide with the
    // final emission cycle of the previous word, giving gapless streaming.
    always_comb begin
        act_d  = act_q;
        ecnt_d = ecnt_q;
        if (complete) begin
            act_d  = 1'b1;
            ecnt_d = '0;
        end else if (act_q) begin
            if (ecnt_q == LAST) begin
                act_d  = 1'b0;
                ecnt_d = '0;
            end else begin
                ecnt_d = ecnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            mode_q <= 2'd0;
            act_q  <= 1'b0;
            ecnt_q <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            act_q  <= act_d;
            ecnt_q <= ecnt_d;
        end
    end

    assign out_valid = act_q;
    assign out_first = act_q & (ecnt_q == '0);
    assign out_last  = act_q & (ecnt_q == LAST);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        twos_compliment_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .cap_en_i   (accept),
            .din_i      (in[gi]),
            .load_i     (complete),
            .mode_i     (mode_q),
            .emit_en_i  (act_q),
            .emit_last_i(out_last),
            .out_o      (out[gi]),
            .ovf_o      (ovf[gi])
        );
    end

endmodule

// File: tb/tb_twos_compliment_mc.sv
// Directed bench for twos_compliment_mc (WIDTH=8, CHANNELS=4).
// Lane words are packed as {lane3, lane2, lane1, lane0}.
module tb_twos_compliment_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din_s;
    logic       in_valid;
    logic       in_first;
    logic [1:0] mode_s;
    logic [3:0] dout;
    logic       out_valid;
    logic       out_first;
    logic       out_last;
    logic [3:0] ovf;

    int checks   = 0;
    int failures = 0;

    twos_compliment_mc #(
        .WIDTH   (8),
        .CHANNELS(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (din_s),
        .in_valid (in_valid),
        .in_first (in_first),
        .mode     (mode_s),
        .out      (dout),
        .out_valid(out_valid),
        .out_first(out_first),
        .out_last (out_last),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- output collector (samples on negedge) ----------------
    typedef struct {
        logic [3:0][7:0] w;
        logic [3:0]      o;
    } rec_t;

    rec_t            recs[$];
    int              runs[$];
    int              firsts[$];
    int              anomalies = 0;
    int              vlen = 0;
    logic [3:0][7:0] acc;
    rec_t            mon_rec;

    always @(negedge clk) begin
        if (out_valid) begin
            if (out_first) begin
                firsts.push_back(cyc);
                if (vlen % 8 != 0) anomalies++;
            end
            for (int l = 0; l < 4; l++) acc[l] = {dout[l], acc[l][7:1]};
            if (out_last) begin
                if (vlen % 8 != 7) anomalies++;
                mon_rec.w = acc;
                mon_rec.o = ovf;
                recs.push_back(mon_rec);
            end else if (|ovf) begin
                anomalies++;
            end
            vlen++;
        end else begin
            if (out_first || out_last || (|dout) || (|ovf)) anomalies++;
            if (vlen != 0) runs.push_back(vlen);
            vlen = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive_beat(input logic v, input logic f, input logic [1:0] m, input logic [3:0] bits);
        in_valid = v;
        in_first = f;
        mode_s   = m;
        din_s    = bits;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_beat(1'b0, 1'b0, 2'd0, 4'h0);
    endtask

    int last_cyc = 0;

    // Non-first beats carry a different mode to show it is ignored there.
    // gap_len idle cycles are inserted before beat gap_at (gap_at<0: none).
    task automatic send_word(input logic [1:0] m, input logic [3:0][7:0] w,
                             input int gap_at, input int gap_len);
        logic [3:0] bits;
        for (int b = 0; b < 8; b++) begin
            if (b == gap_at) idle(gap_len);
            for (int l = 0; l < 4; l++) bits[l] = w[l][b];
            drive_beat(1'b1, b == 0, (b == 0) ? m : ~m, bits);
        end
        last_cyc = cyc;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic wait_words(input int n, input string name);
        int k;
        k = 0;
        while (recs.size() < n && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (recs.size() < n) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d words required=%0d", name, recs.size(), n);
        end
    endtask

    task automatic chk_word(input string name, input logic [31:0] ew, input logic [3:0] eo);
        rec_t r;
        if (recs.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s actual=no_word required=%h", name, ew);
        end else begin
            r = recs.pop_front();
            chk({name, "_word"}, r.w, ew);
            chk({name, "_ovf"}, {28'd0, r.o}, {28'd0, eo});
        end
    endtask

    task automatic chk_run(input string name, input int exp_len);
        int got;
        got = (runs.size() > 0) ? runs.pop_front() : 0;
        chk(name, got, exp_len);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [31:0] din;
        logic [31:0] dexp;
        logic [3:0]  ovf;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"neg",   2'd1, 32'h7F_00_01_05, 32'h81_00_FF_FB, 4'b0000};
        vecs[1] = '{"abs",   2'd2, 32'hFF_80_05_FB, 32'h01_80_05_05, 4'b0100};
        vecs[2] = '{"pass0", 2'd0, 32'h3C_3C_3C_3C, 32'h3C_3C_3C_3C, 4'b0000};
        vecs[3] = '{"pass3", 2'd3, 32'h3C_3C_3C_3C, 32'h3C_3C_3C_3C, 4'b0000};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        mode_s   = 2'd0;
        din_s    = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_first", {31'd0, out_first}, 32'd0);
        chk("reset_out_last",  {31'd0, out_last},  32'd0);
        chk("reset_out",       {28'd0, dout},      32'd0);
        chk("reset_ovf",       {28'd0, ovf},       32'd0);
        rst = 1'b0;
        idle(2);
        recs.delete(); runs.delete(); firsts.delete();

        // Single words from the table
        for (int i = 0; i < 4; i++) begin
            send_word(vecs[i].mode, vecs[i].din, -1, 0);
            wait_words(1, vecs[i].name);
            idle(2);
            chk_word(vecs[i].name, vecs[i].dexp, vecs[i].ovf);
            chk_run({vecs[i].name, "_run"}, 8);
            chk({vecs[i].name, "_latency"}, (firsts.size() > 0) ? firsts.pop_front() : -1, last_cyc);
            $display("vector %s mode=%0d in=%h expect=%h", vecs[i].name, vecs[i].mode, vecs[i].din, vecs[i].dexp);
        end

        // Three back-to-back negate words: one 24-cycle output burst
        send_word(2'd1, 32'hFE_33_10_80, -1, 0);
        send_word(2'd1, 32'h04_03_02_01, -1, 0);
        send_word(2'd1, 32'h55_AA_40_7F, -1, 0);
        wait_words(3, "b2b");
        idle(2);
        chk_word("b2b0", 32'h02_CD_F0_80, 4'b0001);
        chk_word("b2b1", 32'hFC_FD_FE_FF, 4'b0000);
        chk_word("b2b2", 32'hAB_56_C0_81, 4'b0000);
        chk_run("b2b_run", 24);
        $display("sequence b2b three negate words");

        // Input gap of 3 cycles inside a word
        send_word(2'd1, vecs[0].din, 4, 3);
        wait_words(1, "gap");
        idle(2);
        chk_word("gap", vecs[0].dexp, 4'b0000);
        chk_run("gap_run", 8);
        $display("sequence gap negate with 3-cycle hole");

        // Beats without in_first while idle are ignored
        for (int b = 0; b < 8; b++) drive_beat(1'b1, 1'b0, 2'd1, 4'hF);
        idle(12);
        chk("stray_words", recs.size(), 0);
        $display("sequence stray beats without in_first");

        // Restart: in_first at beat 4 drops the partial word
        for (int b = 0; b < 4; b++) drive_beat(1'b1, b == 0, 2'd1, 4'hF);
        send_word(2'd1, 32'h10_08_04_02, -1, 0);
        wait_words(1, "restart");
        idle(12);
        chk_word("restart", 32'hF0_F8_FC_FE, 4'b0000);
        chk("restart_extra", recs.size(), 0);
        chk_run("restart_run", 8);
        $display("sequence restart at beat 4");

        // Reset during emission beat 3
        firsts.delete();
        send_word(2'd1, 32'h02_02_02_02, -1, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_out_first", {31'd0, out_first}, 32'd0);
        chk("rst_mid_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_mid_out",       {28'd0, dout},      32'd0);
        chk("rst_mid_ovf",       {28'd0, ovf},       32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(12);
        chk("rst_no_partial", recs.size(), 0);
        chk_run("rst_cut_run", 4);
        send_word(2'd1, 32'h02_02_02_02, -1, 0);
        wait_words(1, "post_rst");
        idle(2);
        chk_word("post_rst", 32'hFE_FE_FE_FE, 4'b0000);
        $display("sequence reset mid-emission then negate 0x02");

        chk("framing_anomalies", anomalies, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
